// File: rtl/divider.sv
// Multi-cycle restoring radix-2 divider for signed and unsigned operands.
// It produces one quotient bit per clock and registers quotient/remainder when the last bit is done.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   rem_acc;
  logic [WIDTH:0]   div_mag;
  logic [WIDTH-1:0] quo_sh;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   shifted;
  logic             take;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             accept;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + ONE) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                    input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  assign accept = (state == IDLE) || (state == DONE);

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    shifted = {rem_acc[WIDTH-1:0], quo_sh[WIDTH-1]};
    take    = (shifted >= div_mag);
    rem_nxt = take ? (shifted - div_mag) : shifted;
    quo_nxt = {quo_sh[WIDTH-2:0], take};
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk_i) begin
    if (accept && start_i) begin
      rem_acc <= '0;
      quo_sh  <= magnitude(dividend_i, signed_i);
      div_mag <= {1'b0, magnitude(divisor_i, signed_i)};
      neg_q   <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
      neg_r   <= signed_i & dividend_i[WIDTH-1];
    end else if (state == RUN) begin
      rem_acc <= rem_nxt;
      quo_sh  <= quo_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      div_zero_o  <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
          if (start_i) begin
            if (divisor_i == '0) begin
              state       <= DONE;
              done_o      <= 1'b1;
              div_zero_o  <= 1'b1;
              quotient_o  <= '1;
              remainder_o <= dividend_i;
            end else begin
              state  <= RUN;
              busy_o <= 1'b1;
              cnt    <= '0;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state       <= DONE;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            div_zero_o  <= 1'b0;
            quotient_o  <= cond_negate(quo_nxt, neg_q);
            remainder_o <= cond_negate(rem_nxt[WIDTH-1:0], neg_r);
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for the divider: latency, signed/unsigned results,
// zero divisor, overflow, start ignored while busy, mid-run reset and back-to-back ops.
module tb_divider;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic             signed_i = 1'b0;
  logic [WIDTH-1:0] dividend_i = '0;
  logic [WIDTH-1:0] divisor_i = '0;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             busy_o;
  logic             done_o;
  logic             div_zero_o;

  int checks = 0;
  int errors = 0;
  int lat;
  int bcnt;

  divider #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .quotient_o (quotient_o),
    .remainder_o(remainder_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; the next rising edge is E0.
  // poke > 0 pulses start_i (with other operands) so that it is sampled at E<poke>.
  task automatic run_op(input logic s, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int poke,
                        output int latency, output int busy_cycles);
    signed_i   = s;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    latency     = 0;
    busy_cycles = 0;
    forever begin
      @(negedge clk_i);
      latency++;
      start_i = 1'b0;
      if (busy_o) busy_cycles++;
      if (done_o) break;
      if (latency == poke) begin
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd9;
        divisor_i  = 32'd3;
      end
      if (latency > 100) begin
        check("timeout_done", {31'd0, done_o}, 32'd1);
        break;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic expect_res(input string tag, input int latency, input int busy_cycles,
                            input int exp_lat, input int exp_busy,
                            input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                            input logic dz);
    check({tag, "_lat"}, latency, exp_lat);
    check({tag, "_busy"}, busy_cycles, exp_busy);
    check({tag, "_q"}, quotient_o, q);
    check({tag, "_r"}, remainder_o, r);
    check({tag, "_dz"}, {31'd0, div_zero_o}, {31'd0, dz});
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_q", quotient_o, 32'd0);
    check("rst_r", remainder_o, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_dz", {31'd0, div_zero_o}, 32'd0);

    run_op(1'b0, 32'd100, 32'd7, 0, lat, bcnt);
    expect_res("u100_7", lat, bcnt, 33, 32, 32'd14, 32'd2, 1'b0);
    @(negedge clk_i);
    check("done_one_cycle", {31'd0, done_o}, 32'd0);
    check("hold_q_idle", quotient_o, 32'd14);

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, bcnt);
    expect_res("s_m7_2", lat, bcnt, 33, 32, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk_i);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, lat, bcnt);
    expect_res("s_7_m2", lat, bcnt, 33, 32, 32'hFFFF_FFFD, 32'd1, 1'b0);
    @(negedge clk_i);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 0, lat, bcnt);
    expect_res("u_max_16", lat, bcnt, 33, 32, 32'h0FFF_FFFF, 32'hF, 1'b0);
    @(negedge clk_i);

    run_op(1'b0, 32'd5, 32'd0, 0, lat, bcnt);
    expect_res("u_div0", lat, bcnt, 1, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    @(negedge clk_i);
    run_op(1'b1, 32'd5, 32'd0, 0, lat, bcnt);
    expect_res("s_div0", lat, bcnt, 1, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    @(negedge clk_i);
    run_op(1'b0, 32'd9, 32'd3, 0, lat, bcnt);
    expect_res("u9_3", lat, bcnt, 33, 32, 32'd3, 32'd0, 1'b0);
    @(negedge clk_i);

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5, lat, bcnt);
    expect_res("s_ovf", lat, bcnt, 33, 32, 32'h8000_0000, 32'd0, 1'b0);
    @(negedge clk_i);
    check("poke_ignored_busy", {31'd0, busy_o}, 32'd0);
    check("poke_ignored_done", {31'd0, done_o}, 32'd0);

    // Reset asserted so that it is sampled at E10 of 100 / 7.
    signed_i   = 1'b0;
    dividend_i = 32'd100;
    divisor_i  = 32'd7;
    start_i    = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    check("hold_q_run", quotient_o, 32'h8000_0000);
    check("busy_mid_run", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("mid_rst_q", quotient_o, 32'd0);
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_done", {31'd0, done_o}, 32'd0);
    run_op(1'b0, 32'd20, 32'd6, 0, lat, bcnt);
    expect_res("u20_6", lat, bcnt, 33, 32, 32'd3, 32'd2, 1'b0);
    @(negedge clk_i);

    // Second start is presented during the DONE cycle of the first.
    run_op(1'b0, 32'd100, 32'd7, 0, lat, bcnt);
    expect_res("b2b_first", lat, bcnt, 33, 32, 32'd14, 32'd2, 1'b0);
    run_op(1'b0, 32'd50, 32'd5, 0, lat, bcnt);
    expect_res("b2b_second", lat, bcnt, 33, 32, 32'd10, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
